// File: rtl/oc8051_fetch_pkg.sv
// Shared definitions for the oc8051 code-ROM prefetch slice.
package oc8051_fetch_pkg;

    localparam int unsigned BUF_BYTES  = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned MAX_ADV    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_STALL
    } fetch_state_e;

    // Bytes actually consumed: request limited by instruction length and by buffer fill.
    function automatic logic [3:0] clamp_adv(input logic [2:0] adv, input logic [3:0] cnt);
        logic [3:0] a;
        a = {1'b0, adv};
        if (a > 4'(MAX_ADV)) a = 4'(MAX_ADV);
        if (a > cnt)         a = cnt;
        return a;
    endfunction

endpackage

// File: rtl/oc8051_fetch_bytebuf.sv
// 8-byte shift/align buffer: drops consumed bytes from the front and appends
// one ROM word behind the remaining bytes; exposes the first four bytes.
module oc8051_fetch_bytebuf
    import oc8051_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  shift_i,
    input  logic [2:0]  eff_i,
    input  logic        append_i,
    input  logic [31:0] data_i,
    output logic [31:0] win_o
);

    logic [BUF_BYTES*8-1:0] buf_q;
    logic [BUF_BYTES*8-1:0] buf_d;

    always_comb begin
        logic [3:0] src;
        logic [2:0] dst;
        src   = '0;
        dst   = '0;
        buf_d = buf_q;
        // Slots with no source byte keep their old contents (stale but deterministic).
        for (int unsigned i = 0; i < BUF_BYTES; i++) begin
            dst = 3'(i);
            src = 4'(i) + shift_i;
            if (src < 4'(BUF_BYTES)) begin
                buf_d[{dst, 3'b000} +: 8] = buf_q[{src[2:0], 3'b000} +: 8];
            end
        end
        if (append_i) begin
            for (int unsigned j = 0; j < WORD_BYTES; j++) begin
                dst = eff_i + 3'(j);
                buf_d[{dst, 3'b000} +: 8] = data_i[{2'(j), 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign win_o = buf_q[31:0];

endmodule

// File: rtl/oc8051_cxrom_prefetch.sv
// Code-ROM prefetch unit: streams 32-bit words from a combinational ROM into an
// 8-byte window the 8051 core consumes 0..3 bytes at a time.
module oc8051_cxrom_prefetch
    import oc8051_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        redir,
    input  logic [15:0] redir_addr,
    input  logic [2:0]  advance,
    output logic [15:0] cxrom_addr,
    input  logic [31:0] cxrom_data_in,
    output logic [31:0] win_data,
    output logic [3:0]  win_cnt,
    output logic        win_valid,
    output logic [15:0] win_pc,
    output logic        err
);

    fetch_state_e state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic [15:0]  fetch_ptr_q, fetch_ptr_d;
    logic [15:0]  win_pc_q, win_pc_d;
    logic         err_q, err_d;

    logic [3:0]   adv_eff;
    logic [3:0]   eff;
    logic         illegal;
    logic         accept;

    logic [3:0]   buf_shift;
    logic [2:0]   buf_eff;
    logic         buf_append;

    always_comb begin
        adv_eff = clamp_adv(advance, count_q);
        illegal = ({1'b0, advance} > count_q) || (advance > 3'(MAX_ADV));
        eff     = count_q - adv_eff;
        accept  = (state_q == ST_STREAM) && (eff <= 4'(WORD_BYTES));
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        fetch_ptr_d = fetch_ptr_q;
        win_pc_d    = win_pc_q;
        err_d       = err_q;
        buf_shift   = '0;
        buf_eff     = '0;
        buf_append  = 1'b0;

        if (redir) begin
            // Flush and reload from the new stream; advance is ignored.
            state_d     = ST_STREAM;
            count_d     = 4'(WORD_BYTES);
            win_pc_d    = redir_addr;
            fetch_ptr_d = redir_addr + 16'(WORD_BYTES);
            buf_append  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = en ? ST_STREAM : ST_STALL;
                ST_STREAM: if (!en) state_d = ST_STALL;
                ST_STALL:  if (en)  state_d = ST_STREAM;
                default:   state_d = ST_IDLE;
            endcase
            err_d      = err_q | illegal;
            win_pc_d   = win_pc_q + {12'b0, adv_eff};
            buf_shift  = adv_eff;
            buf_eff    = eff[2:0];
            buf_append = accept;
            if (accept) begin
                count_d     = eff + 4'(WORD_BYTES);
                fetch_ptr_d = fetch_ptr_q + 16'(WORD_BYTES);
            end else begin
                count_d     = eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            fetch_ptr_q <= '0;
            win_pc_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            fetch_ptr_q <= fetch_ptr_d;
            win_pc_q    <= win_pc_d;
            err_q       <= err_d;
        end
    end

    oc8051_fetch_bytebuf u_bytebuf (
        .clk      (clk),
        .rst_n    (rst),
        .shift_i  (buf_shift),
        .eff_i    (buf_eff),
        .append_i (buf_append),
        .data_i   (cxrom_data_in),
        .win_o    (win_data)
    );

    assign cxrom_addr = redir ? redir_addr : fetch_ptr_q;
    assign win_cnt    = count_q;
    assign win_valid  = (count_q >= 4'(MAX_ADV));
    assign win_pc     = win_pc_q;
    assign err        = err_q;

endmodule

// File: tb/tb_oc8051_cxrom_prefetch.sv
// Self-checking bench for oc8051_cxrom_prefetch against a byte-queue reference model.
module tb_oc8051_cxrom_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redir;
    logic [15:0] redir_addr;
    logic [2:0]  advance;
    logic [15:0] cxrom_addr;
    logic [31:0] cxrom_data_in;
    logic [31:0] win_data;
    logic [3:0]  win_cnt;
    logic        win_valid;
    logic [15:0] win_pc;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    oc8051_cxrom_prefetch dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .redir         (redir),
        .redir_addr    (redir_addr),
        .advance       (advance),
        .cxrom_addr    (cxrom_addr),
        .cxrom_data_in (cxrom_data_in),
        .win_data      (win_data),
        .win_cnt       (win_cnt),
        .win_valid     (win_valid),
        .win_pc        (win_pc),
        .err           (err)
    );

    // ROM contents: mode 0 is byte k = k[7:0], mode 1 a scrambled pattern.
    logic rom_mode = 1'b0;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        if (!rom_mode) return a[7:0];
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[7:4]};
    endfunction

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {rom_byte(a + 16'd3), rom_byte(a + 16'd2), rom_byte(a + 16'd1), rom_byte(a)};
    endfunction

    always_comb cxrom_data_in = rom_word(cxrom_addr);

    // Reference model: the window is a plain byte queue.
    logic [7:0]  m_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_fptr;
    bit          m_stream;
    bit          m_err;

    logic [15:0] obs_addr;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_mask;

    task automatic model_reset();
        m_q.delete();
        m_pc     = '0;
        m_fptr   = '0;
        m_stream = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit r, input logic [15:0] ra, input int adv);
        int take;
        if (r) begin
            m_q.delete();
            for (int k = 0; k < 4; k++) m_q.push_back(rom_byte(ra + 16'(k)));
            m_pc   = ra;
            m_fptr = ra + 16'd4;
        end else begin
            if (adv > m_q.size() || adv > 3) m_err = 1'b1;
            take = adv;
            if (take > 3) take = 3;
            if (take > m_q.size()) take = m_q.size();
            repeat (take) void'(m_q.pop_front());
            m_pc = m_pc + 16'(take);
            if (m_stream && m_q.size() <= 4) begin
                for (int k = 0; k < 4; k++) m_q.push_back(rom_byte(m_fptr + 16'(k)));
                m_fptr = m_fptr + 16'd4;
            end
        end
        m_stream = r || e;
    endtask

    task automatic model_window();
        exp_data = '0;
        exp_mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < m_q.size()) begin
                exp_data[i*8 +: 8] = m_q[i];
                exp_mask[i*8 +: 8] = 8'hFF;
            end
        end
    endtask

    // Drive one cycle: sample the combinational ROM address, clock, update model.
    task automatic step(input bit e, input bit r, input logic [15:0] ra, input logic [2:0] adv);
        en         = e;
        redir      = r;
        redir_addr = ra;
        advance    = adv;
        #1;
        obs_addr = cxrom_addr;
        exp_addr = r ? ra : m_fptr;
        @(posedge clk);
        model_step(e, r, ra, int'(adv));
        model_window();
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", win_valid); end
        n_checks++; if (win_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", win_cnt); end
        n_checks++; if (win_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", win_data); end
        n_checks++; if (cxrom_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", cxrom_addr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (win_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", win_pc); end
    endtask

    task automatic test_fill();
        rom_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (win_cnt !== 4'd0) begin n_fail++; $display("FAIL fill_idle_cnt: got %0d expected 0", win_cnt); end
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (obs_addr !== 16'h0000) begin n_fail++; $display("FAIL fill_addr0: got %h expected 0000", obs_addr); end
        n_checks++; if (win_cnt !== 4'd4) begin n_fail++; $display("FAIL fill_cnt4: got %0d expected 4", win_cnt); end
        n_checks++; if (win_data !== 32'h03020100) begin n_fail++; $display("FAIL fill_data: got %h expected 03020100", win_data); end
        n_checks++; if (win_pc !== 16'h0) begin n_fail++; $display("FAIL fill_pc: got %h expected 0000", win_pc); end
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (obs_addr !== 16'h0004) begin n_fail++; $display("FAIL fill_addr4: got %h expected 0004", obs_addr); end
        n_checks++; if (win_cnt !== 4'd8) begin n_fail++; $display("FAIL fill_cnt8: got %0d expected 8", win_cnt); end
        n_checks++; if (win_data !== 32'h03020100) begin n_fail++; $display("FAIL fill_data8: got %h expected 03020100", win_data); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 16'h0, 3'd3);
            n_checks++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, win_valid); end
            n_checks++; if (win_pc !== 16'(3*(i+1))) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, win_pc, 16'(3*(i+1))); end
            n_checks++; if (win_data[7:0] !== 8'(3*(i+1))) begin n_fail++; $display("FAIL stream_byte0[%0d]: got %h expected %h", i, win_data[7:0], 8'(3*(i+1))); end
            n_checks++; if (int'(win_cnt) !== m_q.size()) begin n_fail++; $display("FAIL stream_cnt[%0d]: got %0d expected %0d", i, win_cnt, m_q.size()); end
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 16'h0, 3'd0);
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (win_cnt !== 4'd8) begin n_fail++; $display("FAIL redir_pre_cnt: got %0d expected 8", win_cnt); end
        step(1'b1, 1'b1, 16'h1234, 3'd3);
        n_checks++; if (obs_addr !== 16'h1234) begin n_fail++; $display("FAIL redir_addr: got %h expected 1234", obs_addr); end
        n_checks++; if (win_cnt !== 4'd4) begin n_fail++; $display("FAIL redir_cnt: got %0d expected 4", win_cnt); end
        n_checks++; if (win_pc !== 16'h1234) begin n_fail++; $display("FAIL redir_pc: got %h expected 1234", win_pc); end
        n_checks++; if (win_data !== 32'h37363534) begin n_fail++; $display("FAIL redir_data: got %h expected 37363534", win_data); end
        redir = 1'b0;
        #1;
        n_checks++; if (cxrom_addr !== 16'h1238) begin n_fail++; $display("FAIL redir_next_addr: got %h expected 1238", cxrom_addr); end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 16'hFFFE, 3'd0);
        n_checks++; if (obs_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr0: got %h expected fffe", obs_addr); end
        n_checks++; if (win_data !== 32'h0100FFFE) begin n_fail++; $display("FAIL wrap_data: got %h expected 0100fffe", win_data); end
        n_checks++; if (win_pc !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_pc: got %h expected fffe", win_pc); end
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (obs_addr !== 16'h0002) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0002", obs_addr); end
        n_checks++; if (win_cnt !== 4'd8) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 8", win_cnt); end
        n_checks++; if (win_data !== 32'h0100FFFE) begin n_fail++; $display("FAIL wrap_data8: got %h expected 0100fffe", win_data); end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 16'h0, 3'd3);
        n_checks++; if (win_cnt !== 4'd5) begin n_fail++; $display("FAIL stall_pre_cnt: got %0d expected 5", win_cnt); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 16'h0, 3'd1);
            n_checks++; if (obs_addr !== 16'h0006) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 0006", k, obs_addr); end
            n_checks++; if (win_cnt !== 4'(4-k)) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %0d expected %0d", k, win_cnt, 4-k); end
            n_checks++; if (win_valid !== (k < 2)) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected %b", k, win_valid, k < 2); end
        end
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (win_cnt !== 4'd2) begin n_fail++; $display("FAIL stall_resume_cnt: got %0d expected 2", win_cnt); end
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (win_cnt !== 4'd6) begin n_fail++; $display("FAIL stall_refill_cnt: got %0d expected 6", win_cnt); end
        n_checks++; if (win_data !== 32'h07060504) begin n_fail++; $display("FAIL stall_refill_data: got %h expected 07060504", win_data); end
        n_checks++; if (win_pc !== 16'h0004) begin n_fail++; $display("FAIL stall_refill_pc: got %h expected 0004", win_pc); end
    endtask

    task automatic test_error();
        step(1'b0, 1'b0, 16'h0, 3'd0);
        step(1'b0, 1'b0, 16'h0, 3'd3);
        step(1'b0, 1'b0, 16'h0, 3'd1);
        n_checks++; if (win_cnt !== 4'd2) begin n_fail++; $display("FAIL err_pre_cnt: got %0d expected 2", win_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b expected 0", err); end
        step(1'b0, 1'b0, 16'h0, 3'd3);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
        n_checks++; if (win_cnt !== 4'd0) begin n_fail++; $display("FAIL err_cnt: got %0d expected 0", win_cnt); end
        step(1'b0, 1'b0, 16'h0, 3'd0);
        step(1'b1, 1'b0, 16'h0, 3'd0);
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
        n_checks++; if (int'(win_cnt) !== m_q.size()) begin n_fail++; $display("FAIL err_restream_cnt: got %0d expected %0d", win_cnt, m_q.size()); end
        en = 1'b1; redir = 1'b0; advance = 3'd0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", win_valid); end
        n_checks++; if (win_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d expected 0", win_cnt); end
        n_checks++; if (win_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00000000", win_data); end
        n_checks++; if (cxrom_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 0000", cxrom_addr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", err); end
        n_checks++; if (win_pc !== 16'h0) begin n_fail++; $display("FAIL rst_mid_pc: got %h expected 0000", win_pc); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 16'h0, 3'd0);
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (obs_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_first_addr: got %h expected 0000", obs_addr); end
        n_checks++; if (win_data !== 32'h03020100) begin n_fail++; $display("FAIL rst_first_data: got %h expected 03020100", win_data); end
    endtask

    task automatic test_random();
        bit          e;
        bit          r;
        logic [15:0] ra;
        logic [2:0]  adv;
        int          lim;
        rom_mode = 1'b1;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 800; i++) begin
            e  = ($urandom_range(0, 99) < 85);
            r  = ($urandom_range(0, 99) < 6);
            ra = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 16'hFFFC + 16'($urandom_range(0, 3));
            lim = (m_q.size() < 3) ? m_q.size() : 3;
            if ($urandom_range(0, 39) == 0) adv = 3'($urandom_range(0, 7));
            else                            adv = 3'($urandom_range(0, lim));
            step(e, r, ra, adv);
            n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, obs_addr, exp_addr); end
            n_checks++; if (int'(win_cnt) !== m_q.size()) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, win_cnt, m_q.size()); end
            n_checks++; if (win_valid !== (m_q.size() >= 3)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, win_valid, m_q.size() >= 3); end
            n_checks++; if (win_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, win_pc, m_pc); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, err, m_err); end
            n_checks++; if ((win_data & exp_mask) !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h mask %h", i, win_data, exp_data, exp_mask); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [5];
        addrs = '{16'hFFFD, 16'h0000, 16'h8001, 16'h7FFF, 16'hABCD};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, addrs[i], 3'($urandom_range(0, 7)));
            n_checks++; if (obs_addr !== addrs[i]) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, obs_addr, addrs[i]); end
            n_checks++; if (win_pc !== addrs[i]) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, win_pc, addrs[i]); end
            n_checks++; if (win_cnt !== 4'd4) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d expected 4", i, win_cnt); end
            n_checks++; if (win_data !== exp_data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, win_data, exp_data); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL b2b_err[%0d]: got %b expected %b", i, err, m_err); end
        end
        step(1'b1, 1'b0, 16'h0, 3'd0);
        n_checks++; if (obs_addr !== 16'hABD1) begin n_fail++; $display("FAIL b2b_follow_addr: got %h expected abd1", obs_addr); end
        n_checks++; if (win_cnt !== 4'd8) begin n_fail++; $display("FAIL b2b_follow_cnt: got %0d expected 8", win_cnt); end
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        redir      = 1'b0;
        redir_addr = '0;
        advance    = '0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_wrap();
        test_stall();
        test_error();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
